addr_mode_tracer: RTL

//  Parametrised trace/statistics unit for the 6502 decode stage; succeeds the print-only mode monitor.
//  On each newinst pulse it encodes the one-hot addressing-mode vector into a 4-bit class and pushes
//  {opcode, class} into a circular trace FIFO. It also keeps per-class saturating hit counters and

---
 rtl/addr_mode_tracer_if.sv | 34 +++
 rtl/addr_mode_tracer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/addr_mode_tracer_if.sv
// Capture, trace-read and statistics signals of addr_mode_tracer.
// slave = the tracer itself, master = the decoder/debug-bus side.
interface addr_mode_tracer_if #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16,
  parameter int OPC_W = 8
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             newinst;
  logic [OPC_W-1:0] instruction;
  logic [12:0]      mode_vec;
  logic             freeze;
  logic             rd_ready;
  logic             rd_valid;
  logic [OPC_W-1:0] rd_opcode;
  logic [3:0]       rd_mode;
  logic [LVL_W-1:0] level;
  logic [3:0]       cnt_sel;
  logic [CNT_W-1:0] cnt_value;
  logic             clr_stats;
  logic             overflow;
  logic             conflict;

  modport master (
    output newinst, instruction, mode_vec, freeze, rd_ready, cnt_sel, clr_stats,
    input  rd_valid, rd_opcode, rd_mode, level, cnt_value, overflow, conflict
  );

  modport slave (
    input  newinst, instruction, mode_vec, freeze, rd_ready, cnt_sel, clr_stats,
    output rd_valid, rd_opcode, rd_mode, level, cnt_value, overflow, conflict
  );
endinterface

// File: rtl/addr_mode_tracer.sv
// Addressing-mode trace FIFO with per-class saturating hit counters and sticky error flags.
// Optional MODE_TRACE_DISPLAY_EN adds simulation-only $display messages per capture/drop.
module addr_mode_tracer #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16,
  parameter int OPC_W = 8
) (
  input logic               clk,
  input logic               rst,
  addr_mode_tracer_if.slave bus_io
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ENT_W = OPC_W + 4;
  localparam int NCLS  = 15;

  localparam logic [3:0] CLS_UNKNOWN  = 4'd13;
  localparam logic [3:0] CLS_CONFLICT = 4'd14;

  logic [ENT_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [ENT_W-1:0] head_q, head_d;
  logic             overflow_q, overflow_d;
  logic             conflict_q, conflict_d;

  logic             capture;
  logic             pop;
  logic             full;
  logic             drop;
  logic [3:0]       ones;
  logic [3:0]       idx;
  logic [3:0]       cls;
  logic [ENT_W-1:0] wdata;
  logic [CNT_W-1:0] cnt_all [NCLS];
  logic [CNT_W-1:0] cnt_mux;

  // One-hot to class: 13 when no bit is set, 14 when several are set.
  always_comb begin
    ones = '0;
    idx  = '0;
    for (int i = 0; i < 13; i++) begin
      if (bus_io.mode_vec[i]) begin
        ones = ones + 4'd1;
        idx  = 4'(i);
      end
    end
    if (ones == 4'd0) begin
      cls = CLS_UNKNOWN;
    end else if (ones == 4'd1) begin
      cls = idx;
    end else begin
      cls = CLS_CONFLICT;
    end
  end

  assign capture = bus_io.newinst & ~bus_io.freeze;
  assign pop     = (level_q != '0) & bus_io.rd_ready;
  assign full    = (level_q == LVL_W'(DEPTH));
  assign drop    = full & capture & ~pop;
  assign wdata   = {bus_io.instruction, cls};

  always_comb begin
    wr_ptr_d   = wr_ptr_q + PTR_W'(capture);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop | drop);
    level_d    = level_q;
    if (capture && !pop && !full) begin
      level_d = level_q + LVL_W'(1);
    end else if (!capture && pop) begin
      level_d = level_q - LVL_W'(1);
    end
    overflow_d = (bus_io.clr_stats ? 1'b0 : overflow_q) | drop;
    conflict_d = (bus_io.clr_stats ? 1'b0 : conflict_q) | (capture & (cls == CLS_CONFLICT));
  end

  // Head register is the show-ahead view; bypass when the slot being written becomes the head.
  always_comb begin
    if (capture && (wr_ptr_q == rd_ptr_d)) begin
      head_d = wdata;
    end else begin
      head_d = mem[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      mem[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      head_q     <= '0;
      overflow_q <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      head_q     <= head_d;
      overflow_q <= overflow_d;
      conflict_q <= conflict_d;
    end
  end

  for (genvar gi = 0; gi < NCLS; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q, cnt_d, base;

    // A clear in the same cycle as a capture still counts that capture.
    always_comb begin
      base  = bus_io.clr_stats ? '0 : cnt_q;
      cnt_d = base;
      if (capture && (cls == 4'(gi)) && (base != '1)) begin
        cnt_d = base + CNT_W'(1);
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign cnt_all[gi] = cnt_q;
  end

  always_comb begin
    cnt_mux = '0;
    if (bus_io.cnt_sel != 4'd15) begin
      cnt_mux = cnt_all[bus_io.cnt_sel];
    end
  end

  assign bus_io.rd_valid  = (level_q != '0);
  assign bus_io.rd_opcode = head_q[ENT_W-1:4];
  assign bus_io.rd_mode   = head_q[3:0];
  assign bus_io.level     = level_q;
  assign bus_io.cnt_value = cnt_mux;
  assign bus_io.overflow  = overflow_q;
  assign bus_io.conflict  = conflict_q;

`ifdef MODE_TRACE_DISPLAY_EN
  function automatic string mode_name(input logic [3:0] c);
    case (c)
      4'd0:    return "immediate";
      4'd1:    return "absolute";
      4'd2:    return "zpg_absolute";
      4'd3:    return "implied";
      4'd4:    return "accumulator";
      4'd5:    return "abs_indexed_x";
      4'd6:    return "abs_indexed_y";
      4'd7:    return "zpg_indexed_x";
      4'd8:    return "zpg_indexed_y";
      4'd9:    return "indirect";
      4'd10:   return "indirect_x";
      4'd11:   return "indirect_y";
      4'd12:   return "relative";
      4'd13:   return "unknown";
      default: return "conflict";
    endcase
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      if (capture) begin
        $display("%s %x", mode_name(cls), bus_io.instruction);
      end
      if (drop) begin
        $display("trace overflow %x", head_q[ENT_W-1:4]);
      end
    end
  end
`else
  // Synthesis build: no messages, port behaviour identical.
`endif

endmodule
